// File: rtl/fpu_cvt_sched_if.sv
// Request/result bundle for fpu_cvt_sched.
//   Requester A (load path) and B (execute path): req/op/src/tag in, gnt out.
//   op 0 = single-to-double, 1 = double-to-single; single operands and
//   results live in the low 32 bits.
//   Result channel: dst_valid/dst/dst_tag/dst_src out, dst_ready in.
// slave modport is the converter side, master is the requester/consumer side.
interface fpu_cvt_sched_if;
  logic        a_req;
  logic        a_op;
  logic [63:0] a_src;
  logic [3:0]  a_tag;
  logic        a_gnt;
  logic        b_req;
  logic        b_op;
  logic [63:0] b_src;
  logic [3:0]  b_tag;
  logic        b_gnt;
  logic        dst_valid;
  logic        dst_ready;
  logic [63:0] dst;
  logic [3:0]  dst_tag;
  logic        dst_src;

  modport slave (
    input  a_req, a_op, a_src, a_tag,
    input  b_req, b_op, b_src, b_tag,
    input  dst_ready,
    output a_gnt, b_gnt,
    output dst_valid, dst, dst_tag, dst_src
  );

  modport master (
    output a_req, a_op, a_src, a_tag,
    output b_req, b_op, b_src, b_tag,
    output dst_ready,
    input  a_gnt, b_gnt,
    input  dst_valid, dst, dst_tag, dst_src
  );
endinterface

// File: rtl/fpu_cvt_sched.sv
// Two-requester single<->double precision converter with round-robin arbiter.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : fpu_cvt_sched_if.slave (requests A/B, grants, result channel)
// One operation at a time: IDLE (grant) -> CONV (compute) -> HOLD (present
// result until dst_ready). PRIO_B selects who wins the first contention.
module fpu_cvt_sched #(
  parameter bit PRIO_B = 1'b0
) (
  input  logic clk,
  input  logic reset,
  fpu_cvt_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  typedef struct packed {
    logic        op;
    logic [63:0] src;
    logic [3:0]  tag;
    logic        who;   // 0 = A, 1 = B
  } req_t;

  state_t state, state_nx;
  req_t   req_in, req_q;
  logic   pri;          // 1 = B wins the next contention
  logic   grant;
  logic   gsel;         // 1 = grant goes to B

  // Conversion of the latched operand. Exponents are rebiased in 12 bits so
  // an out-of-range value shows up as a borrow/large value instead of wrapping.
  function automatic logic [63:0] cvt(input logic op, input logic [63:0] s);
    logic [7:0]  e;
    logic [10:0] ex;
    logic [11:0] ed;
    logic [11:0] es;
    logic [63:0] r;
    e  = s[30:23];
    ex = s[62:52];
    ed = {4'b0, e} + 12'd896;
    es = {1'b0, ex} - 12'd896;
    r  = '0;
    if (!op) begin
      if (e == 8'h00)
        r = '0;
      else if (e == 8'hFF)
        r = {s[31], 11'h7FF, s[22:0], 29'b0};
      else
        // ed never carries for e in 1..254; saturating keeps it from wrapping.
        r = {s[31], ed[10:0] | {11{ed[11]}}, s[22:0], 29'b0};
    end else begin
      if (ex == 11'h000)
        r = '0;
      else if (ex == 11'h7FF)
        r = {32'b0, s[63], 8'hFF, s[51:29]};
      else if (es[11] || es == 12'd0)      // E <= 896: underflow to signed zero
        r = {32'b0, s[63], 31'b0};
      else if (es >= 12'd255)              // E >= 1151: overflow to signed inf
        r = {32'b0, s[63], 8'hFF, 23'b0};
      else
        r = {32'b0, s[63], es[7:0], s[51:29]};
    end
    return r;
  endfunction

  // Arbitration: a lone requester always wins; on contention pri decides.
  always_comb begin
    grant  = (state == IDLE) && (bus.a_req || bus.b_req);
    gsel   = bus.b_req && (!bus.a_req || pri);
    req_in = gsel ? '{op: bus.b_op, src: bus.b_src, tag: bus.b_tag, who: 1'b1}
                  : '{op: bus.a_op, src: bus.a_src, tag: bus.a_tag, who: 1'b0};
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = CONV;
      CONV:    state_nx = HOLD;
      HOLD:    if (bus.dst_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs. Grants are combinational in IDLE so the accept lands on the same
  // edge; they are masked during reset since the FSM sits in IDLE then.
  always_comb begin
    bus.a_gnt     = grant && !gsel && !reset;
    bus.b_gnt     = grant &&  gsel && !reset;
    bus.dst_valid = (state == HOLD);
  end

  // Operand latch, round-robin pointer and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q       <= '0;
      pri         <= PRIO_B;
      bus.dst     <= '0;
      bus.dst_tag <= '0;
      bus.dst_src <= 1'b0;
    end else begin
      if (grant) begin
        req_q <= req_in;
        pri   <= !gsel;   // the requester not granted now wins next time
      end
      if (state == CONV) begin
        bus.dst     <= cvt(req_q.op, req_q.src);
        bus.dst_tag <= req_q.tag;
        bus.dst_src <= req_q.who;
      end
    end
  end

endmodule

// File: tb/tb_fpu_cvt_sched.sv
module tb_fpu_cvt_sched;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpu_cvt_sched_if bus();

  fpu_cvt_sched #(.PRIO_B(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        side;   // 0 = A, 1 = B
    logic        op;
    logic [63:0] src;
    logic [3:0]  tag;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive just after the rising edge, sample on the falling edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.a_req = 0; bus.a_op = 0; bus.a_src = '0; bus.a_tag = '0;
    bus.b_req = 0; bus.b_op = 0; bus.b_src = '0; bus.b_tag = '0;
  endtask

  // Waits (bounded) for the grant of one side; leaves time at that cycle's negedge.
  task automatic wait_gnt(input logic side, output bit got);
    got = 0;
    for (int n = 0; n < 8; n++) begin
      smp();
      if ((side ? bus.b_gnt : bus.a_gnt) === 1'b1) begin
        got = 1;
        break;
      end
      step();
    end
  endtask

  task automatic run_op(input vec_t v);
    bit got;
    if (!v.side) begin
      bus.a_req = 1; bus.a_op = v.op; bus.a_src = v.src; bus.a_tag = v.tag;
    end else begin
      bus.b_req = 1; bus.b_op = v.op; bus.b_src = v.src; bus.b_tag = v.tag;
    end
    wait_gnt(v.side, got);
    chk("gnt_seen", {63'b0, got}, 64'd1);
    chk("gnt_other", {63'b0, v.side ? bus.a_gnt : bus.b_gnt}, 64'd0);
    step();
    idle_inputs();
    smp();
    chk("valid_n1", {63'b0, bus.dst_valid}, 64'd0);
    step();
    smp();
    chk("valid_n2", {63'b0, bus.dst_valid}, 64'd1);
    chk("dst", bus.dst, v.exp);
    chk("dst_tag", {60'b0, bus.dst_tag}, {60'b0, v.tag});
    chk("dst_src", {63'b0, bus.dst_src}, {63'b0, v.side});
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;

    tbl[0]  = '{1'b0, 1'b0, 64'h0000_0000_3F80_0000, 4'd5,  64'h3FF0_0000_0000_0000};
    tbl[1]  = '{1'b1, 1'b1, 64'hC009_21FB_5444_2D18, 4'd3,  64'h0000_0000_C049_0FDA};
    tbl[2]  = '{1'b0, 1'b0, 64'h0000_0000_7F80_0001, 4'd1,  64'h7FF0_0000_2000_0000};
    tbl[3]  = '{1'b1, 1'b0, 64'h0000_0000_8000_0001, 4'd2,  64'h0};
    tbl[4]  = '{1'b0, 1'b1, 64'h47F0_0000_0000_0000, 4'd7,  64'h0000_0000_7F80_0000};
    tbl[5]  = '{1'b1, 1'b1, 64'hB690_0000_0000_0000, 4'd9,  64'h0000_0000_8000_0000};
    tbl[6]  = '{1'b0, 1'b0, 64'h0000_0000_C049_0FDA, 4'hF,  64'hC009_21FB_4000_0000};
    tbl[7]  = '{1'b0, 1'b1, 64'h3FF0_0000_0000_0000, 4'd4,  64'h0000_0000_3F80_0000};
    tbl[8]  = '{1'b1, 1'b1, 64'h7FF0_0000_0000_0001, 4'd6,  64'h0000_0000_7F80_0000};
    tbl[9]  = '{1'b1, 1'b1, 64'h3810_0000_0000_0000, 4'd8,  64'h0000_0000_0080_0000};
    tbl[10] = '{1'b0, 1'b0, 64'hDEAD_BEEF_3F80_0000, 4'hA,  64'h3FF0_0000_0000_0000};

    // Reset state, with both requests high to show grants are masked.
    reset = 1;
    idle_inputs();
    bus.dst_ready = 1;
    bus.a_req = 1; bus.b_req = 1;
    #12;
    smp();
    chk("rst_a_gnt", {63'b0, bus.a_gnt}, 64'd0);
    chk("rst_b_gnt", {63'b0, bus.b_gnt}, 64'd0);
    chk("rst_valid", {63'b0, bus.dst_valid}, 64'd0);
    chk("rst_dst", bus.dst, 64'd0);
    chk("rst_tag", {60'b0, bus.dst_tag}, 64'd0);
    chk("rst_src", {63'b0, bus.dst_src}, 64'd0);
    step();
    reset = 0;
    idle_inputs();
    step();

    foreach (tbl[i]) run_op(tbl[i]);

    // Round robin with both requesters held high: A, B, A, B every 3 cycles.
    reset = 1;
    step();
    reset = 0;
    bus.a_req = 1; bus.a_op = 0; bus.a_src = 64'h3F80_0000; bus.a_tag = 4'd1;
    bus.b_req = 1; bus.b_op = 1; bus.b_src = 64'hC009_21FB_5444_2D18; bus.b_tag = 4'd2;
    for (int c = 0; c < 12; c++) begin
      smp();
      chk($sformatf("rr_a_gnt_c%0d", c), {63'b0, bus.a_gnt}, {63'b0, (c % 6) == 0});
      chk($sformatf("rr_b_gnt_c%0d", c), {63'b0, bus.b_gnt}, {63'b0, (c % 6) == 3});
      if (c % 3 == 2) begin
        chk($sformatf("rr_valid_c%0d", c), {63'b0, bus.dst_valid}, 64'd1);
        chk($sformatf("rr_src_c%0d", c), {63'b0, bus.dst_src}, {63'b0, (c % 6) == 5});
      end
      step();
    end
    idle_inputs();
    step();

    // Backpressure: result held while dst_ready is low, B kept waiting.
    bus.dst_ready = 0;
    bus.a_req = 1; bus.a_op = 1; bus.a_src = 64'h3FF0_0000_0000_0000; bus.a_tag = 4'd6;
    wait_gnt(1'b0, got);
    chk("bp_gnt", {63'b0, got}, 64'd1);
    step();
    idle_inputs();
    bus.b_req = 1; bus.b_op = 0; bus.b_src = 64'h7F80_0001; bus.b_tag = 4'd8;
    smp();
    chk("bp_conv_valid", {63'b0, bus.dst_valid}, 64'd0);
    step();
    smp();
    chk("bp_hold_valid", {63'b0, bus.dst_valid}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      smp();
      chk($sformatf("bp_valid_%0d", k), {63'b0, bus.dst_valid}, 64'd1);
      chk($sformatf("bp_dst_%0d", k), bus.dst, 64'h3F80_0000);
      chk($sformatf("bp_tag_%0d", k), {60'b0, bus.dst_tag}, 64'd6);
      chk($sformatf("bp_b_gnt_%0d", k), {63'b0, bus.b_gnt}, 64'd0);
    end
    step();
    bus.dst_ready = 1;
    smp();
    chk("bp_hs_valid", {63'b0, bus.dst_valid}, 64'd1);
    chk("bp_hs_b_gnt", {63'b0, bus.b_gnt}, 64'd0);
    step();
    smp();
    chk("bp_after_valid", {63'b0, bus.dst_valid}, 64'd0);
    chk("bp_after_b_gnt", {63'b0, bus.b_gnt}, 64'd1);
    step();
    idle_inputs();
    step();
    smp();
    chk("bp_b_dst", bus.dst, 64'h7FF0_0000_2000_0000);
    chk("bp_b_tag", {60'b0, bus.dst_tag}, 64'd8);
    chk("bp_b_src", {63'b0, bus.dst_src}, 64'd1);
    step();

    // Reset pulse while in CONV: the op is dropped, the held request re-granted.
    bus.a_req = 1; bus.a_op = 0; bus.a_src = 64'h3F80_0000; bus.a_tag = 4'd4;
    wait_gnt(1'b0, got);
    chk("rc_gnt", {63'b0, got}, 64'd1);
    step();
    reset = 1;
    #1;
    chk("rc_valid", {63'b0, bus.dst_valid}, 64'd0);
    chk("rc_dst", bus.dst, 64'd0);
    chk("rc_tag", {60'b0, bus.dst_tag}, 64'd0);
    chk("rc_src", {63'b0, bus.dst_src}, 64'd0);
    for (int k = 0; k < 2; k++) begin
      smp();
      chk($sformatf("rc_hold_valid_%0d", k), {63'b0, bus.dst_valid}, 64'd0);
      chk($sformatf("rc_hold_gnt_%0d", k), {63'b0, bus.a_gnt}, 64'd0);
      step();
    end
    reset = 0;
    smp();
    chk("rc_regrant", {63'b0, bus.a_gnt}, 64'd1);
    step();
    idle_inputs();
    smp();
    chk("rc_conv_valid", {63'b0, bus.dst_valid}, 64'd0);
    step();
    smp();
    chk("rc_done_valid", {63'b0, bus.dst_valid}, 64'd1);
    chk("rc_done_dst", bus.dst, 64'h3FF0_0000_0000_0000);
    chk("rc_done_tag", {60'b0, bus.dst_tag}, 64'd4);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
